// File: rtl/move_input_conditioner_if.sv
// Button-to-move bus: raw button levels in, move command and debounced levels out.
interface move_input_conditioner_if;
  logic       in_btn_left;
  logic       in_btn_right;
  logic       in_btn_rotate;
  logic [1:0] out_move;
  logic [2:0] out_btn_stable;

  modport master (output in_btn_left, in_btn_right, in_btn_rotate,
                  input  out_move, out_btn_stable);
  modport slave  (input  in_btn_left, in_btn_right, in_btn_rotate,
                  output out_move, out_btn_stable);
endinterface

// File: rtl/move_input_conditioner.sv
// Raw push-buttons -> synchronised, debounced, edge-detected, priority-encoded 1-cycle move pulse.
// Define AUTO_REPEAT_EN to add auto-repeat of held left/right buttons.
module move_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      // any bounce back to the accepted level restarts the qualification window
      if (sync_q[1] == stable) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        stable <= sync_q[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

module move_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 4,
  parameter int CNT_W           = 8
) (
  input  logic                     in_clka,
  input  logic                     in_restart,
  move_input_conditioner_if.slave  bus
);
  localparam int NUM_BTN = 3;  // bit order {rotate, right, left}

  if (DEBOUNCE_CYCLES < 1 || REPEAT_RATE < 1 || REPEAT_DELAY < 1 ||
      (2 ** CNT_W) < DEBOUNCE_CYCLES || (2 ** CNT_W) < REPEAT_DELAY) begin : g_bad_cfg
    $error("move_input_conditioner: illegal counter configuration");
  end

  logic [NUM_BTN-1:0] raw, stable, stable_d, press;
  logic [1:0]         move_nxt, move_q;
  logic               any_press;

  assign raw = {bus.in_btn_rotate, bus.in_btn_right, bus.in_btn_left};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    move_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk   (in_clka),
      .rst   (in_restart),
      .raw   (raw[i]),
      .stable(stable[i])
    );
  end

  always_ff @(posedge in_clka) begin
    if (in_restart) stable_d <= '0;
    else            stable_d <= stable;
  end

  assign press     = stable & ~stable_d;
  assign any_press = |press;

  // simultaneous left+right is ambiguous, so both are dropped
  always_comb begin
    move_nxt = 2'b00;
    if (press[2])                 move_nxt = 2'b11;
    else if (press[0] & press[1]) move_nxt = 2'b00;
    else if (press[0])            move_nxt = 2'b01;
    else if (press[1])            move_nxt = 2'b10;
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic             rep_armed, rep_first, rep_dir;  // rep_dir: 0 left, 1 right
  logic [CNT_W-1:0] rep_cnt;
  logic             rep_held, rep_due, rep_fire;

  assign rep_held = rep_dir ? stable[1] : stable[0];
  assign rep_due  = rep_cnt == (rep_first ? DELAY_LAST : RATE_LAST);
  // a fresh press always wins over a pending repeat
  assign rep_fire = rep_armed & rep_held & rep_due & ~any_press;

  always_ff @(posedge in_clka) begin
    if (in_restart) begin
      rep_armed <= 1'b0;
      rep_first <= 1'b0;
      rep_dir   <= 1'b0;
      rep_cnt   <= '0;
      move_q    <= 2'b00;
    end else if (any_press) begin
      rep_armed <= (move_nxt == 2'b01) || (move_nxt == 2'b10);
      rep_first <= 1'b1;
      rep_dir   <= move_nxt[1];
      rep_cnt   <= '0;
      move_q    <= move_nxt;
    end else begin
      move_q <= rep_fire ? {rep_dir, ~rep_dir} : 2'b00;
      if (rep_armed) begin
        if (!rep_held) begin
          rep_armed <= 1'b0;
        end else if (rep_due) begin
          rep_first <= 1'b0;
          rep_cnt   <= '0;
        end else begin
          rep_cnt <= rep_cnt + CNT_W'(1);
        end
      end
    end
  end
`else
  always_ff @(posedge in_clka) begin
    if (in_restart) move_q <= 2'b00;
    else            move_q <= move_nxt;
  end
`endif

  assign bus.out_move       = move_q;
  assign bus.out_btn_stable = stable;
endmodule
